wb_dmem_responder: RTL and testbench
====================================

# wb_dmem_responder

Memory-side responder for the write-back data cache line interface: accepts whole-line read (allocate) and write (write-back) requests from the data cache controller, services them from an internal word-organised memory array one word per beat after a programmable access latency, and returns a single-cycle acknowledge. It honours the controller's kill pulse and is ready for the back-to-back write-back → allocate sequence the controller issues. It sits between the data cache and the data bus as the synthesizable/simulation backing store.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 128, cache line width in bits
- WORD_WIDTH, 32, memory word width; BEATS = LINE_WIDTH/WORD_WIDTH (must be integer ≥1)
- MEM_LINES, 1024, number of lines stored (power of 2)
- WAIT_CYCLES, 2, access latency before first beat (0..15)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dcache2mem_req_i  in  1  request, held high until ack
- dcache2mem_wr_i  in  1  1 = line write, 0 = line read; valid with req
- dcache2mem_kill_i  in  1  abort current transaction
- dcache2mem_addr_i  in  ADDR_WIDTH  byte address; offset bits ignored
- dcache2mem_wdata_i  in  LINE_WIDTH  write line; word k = bits [k*WORD_WIDTH +: WORD_WIDTH]
- mem2dcache_ack_o  out  1  one-cycle completion pulse
- mem2dcache_rdata_o  out  LINE_WIDTH  read line, valid in ack cycle, held until next read completes
- mem_busy_o  out  1  high in any state other than IDLE

## Operation
- Line index = addr[log2(LINE_WIDTH/8) +: log2(MEM_LINES)]; upper address bits ignored (aliasing wrap). Word address = index*BEATS + beat.
- Memory array BEATS*MEM_LINES words, combinational read, synchronous write; contents not reset.
- States: IDLE, WAIT, XFER, RESP.
- IDLE: if req & ~kill → latch addr, wr, wdata into request registers; beat counter ← 0; latency counter ← WAIT_CYCLES; go WAIT (or XFER if WAIT_CYCLES = 0). Otherwise stay.
- WAIT: decrement latency counter; when it reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT) go XFER.
- XFER: one beat per cycle. Write: mem[word addr] ← latched wdata word[beat]. Read: line buffer word[beat] ← mem[word addr]. Beat counter increments; after beat BEATS-1 go RESP.
- RESP: ack = 1 for exactly this cycle (unless kill); rdata register ← line buffer for reads; go IDLE. Request inputs during RESP are ignored (controller re-asserts req for allocate in the ack cycle; it is sampled next cycle in IDLE).
- Request inputs are sampled only in IDLE; changes to addr/wr/wdata/req mid-transaction have no effect.
- Kill (any state, any cycle): next state IDLE, ack forced 0 that cycle, counters cleared, rdata unchanged. Beats already written stay written (partial line write is accepted); the beat in the kill cycle is not written. Kill in IDLE with req high: request not accepted.

## Timing
- Reset: state IDLE, ack 0, rdata 0, busy 0, counters 0, request registers 0.
- Request accepted in cycle T (IDLE, req=1): ack in cycle T+1+WAIT_CYCLES+BEATS (defaults: T+7). Read data visible on rdata from cycle T+WAIT_CYCLES+BEATS+2 onward... precisely, rdata register updates at the end of the ack cycle; rdata_o is driven from the line buffer combinationally during RESP so it is valid in the ack cycle itself.
- Back-to-back: after ack in cycle A, a held request is accepted in A+1 (IDLE); minimum request spacing 2+WAIT_CYCLES+BEATS cycles.
- Write data visible to a subsequent read of the same line: next accepted read returns it.
- busy rises the cycle after acceptance, falls the cycle after RESP or kill.
- Reset mid-transaction: returns to reset state next edge; no ack; array contents retained.

## Test plan
- Write line 0x00000040 with data 0x44443333_22221111_00000000_DEADBEEF, then read 0x00000040 → write ack at T+7, read ack 7 cycles after acceptance, rdata equals written line.
- Write-back → allocate: write 0x100 (data A) then req held high with wr=0, addr 0x200 in ack cycle → read accepted cycle after ack, ack 7 cycles later, rdata = prior contents of 0x200.
- Kill during XFER beat 2 of a write of all-ones to line 0x80 (line previously zero) → no ack, busy low next cycle, subsequent read returns words 0,1 = 0xFFFFFFFF, words 2,3 = 0.
- Kill coincident with RESP → ack stays 0; next request proceeds normally.
- Alias: write 0x10 then read 0x10 + MEM_LINES*16 → same data returned.
- WAIT_CYCLES=0 build: read accepted at T → ack at T+5; req/addr toggled during XFER → no effect on result.

Source files
------------

// File: rtl/wb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_dmem_responder                                               |
// | Brief    : Line-granular backing store for the write-back data cache.      |
// |            Serves whole-line reads/writes one word per beat after a fixed  |
// |            access latency and returns a single-cycle acknowledge.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int WORD_WIDTH  = 32,
    parameter int MEM_LINES   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic                  dcache2mem_kill_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_wdata_i,
    output logic                  mem2dcache_ack_o,
    output logic [LINE_WIDTH-1:0] mem2dcache_rdata_o,
    output logic                  mem_busy_o
);

    localparam int BEATS      = LINE_WIDTH / WORD_WIDTH;
    localparam int OFF_BITS   = $clog2(LINE_WIDTH / 8);
    localparam int IDX_BITS   = $clog2(MEM_LINES);
    localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS      = BEATS * MEM_LINES;
    localparam int WADDR_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_ack;
    logic                   w_last_beat;
    logic                   w_mem_we;
    logic [WADDR_BITS-1:0]  w_waddr;
    logic [WORD_WIDTH-1:0]  w_rd_word;

    logic [IDX_BITS-1:0]    r_idx;
    logic                   r_wr;
    logic [LINE_WIDTH-1:0]  r_wdata;
    logic [BEAT_BITS-1:0]   r_beat;
    logic [3:0]             r_lat;
    logic [LINE_WIDTH-1:0]  r_lbuf;
    logic [LINE_WIDTH-1:0]  r_rdata;

    logic [WORD_WIDTH-1:0]  r_mem [WORDS];

    assign w_last_beat = (r_beat == BEAT_BITS'(BEATS - 1));
    assign w_waddr     = WADDR_BITS'(r_idx) * WADDR_BITS'(BEATS) + WADDR_BITS'(r_beat);
    assign w_rd_word   = r_mem[w_waddr];
    // Reset is gated in so a transaction cut short by reset leaves no stray beat.
    assign w_mem_we    = (r_state == S_XFER) && r_wr && !dcache2mem_kill_i && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dcache2mem_req_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_XFER : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat <= 4'd1) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_last_beat) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_ack       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (dcache2mem_kill_i) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_ack       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_lbuf  <= '0;
            r_rdata <= '0;
        end else if (dcache2mem_kill_i) begin
            r_beat <= '0;
            r_lat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= dcache2mem_addr_i[OFF_BITS +: IDX_BITS];
                        r_wr    <= dcache2mem_wr_i;
                        r_wdata <= dcache2mem_wdata_i;
                        r_beat  <= '0;
                        r_lat   <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    r_lat <= r_lat - 4'd1;
                end
                S_XFER: begin
                    if (!r_wr) begin
                        r_lbuf[r_beat*WORD_WIDTH +: WORD_WIDTH] <= w_rd_word;
                    end
                    r_beat <= w_last_beat ? '0 : r_beat + BEAT_BITS'(1);
                end
                S_RESP: begin
                    if (!r_wr) begin
                        r_rdata <= r_lbuf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= r_wdata[r_beat*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign mem2dcache_ack_o   = w_ack;
    assign mem2dcache_rdata_o = ((r_state == S_RESP) && !r_wr && !dcache2mem_kill_i) ? r_lbuf : r_rdata;
    assign mem_busy_o         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_dmem_responder                                            |
// | Brief    : Scoreboard bench for wb_dmem_responder (default and zero-wait). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_dmem_responder;

    localparam int C_AW = 32;
    localparam int C_LW = 128;
    localparam int C_ML = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0;
    logic            req = 1'b0, wr = 1'b0, kill = 1'b0;
    logic [C_AW-1:0] addr = '0;
    logic [C_LW-1:0] wdata = '0;
    logic            ack, busy;
    logic [C_LW-1:0] rdata;

    logic            req0 = 1'b0, wr0 = 1'b0, kill0 = 1'b0;
    logic [C_AW-1:0] addr0 = '0;
    logic [C_LW-1:0] wdata0 = '0;
    logic            ack0, busy0;
    logic [C_LW-1:0] rdata0;

    wb_dmem_responder #(.ADDR_WIDTH(C_AW), .LINE_WIDTH(C_LW), .WORD_WIDTH(32),
                        .MEM_LINES(C_ML), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .dcache2mem_req_i(req), .dcache2mem_wr_i(wr), .dcache2mem_kill_i(kill),
        .dcache2mem_addr_i(addr), .dcache2mem_wdata_i(wdata),
        .mem2dcache_ack_o(ack), .mem2dcache_rdata_o(rdata), .mem_busy_o(busy)
    );

    wb_dmem_responder #(.ADDR_WIDTH(C_AW), .LINE_WIDTH(C_LW), .WORD_WIDTH(32),
                        .MEM_LINES(C_ML), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .dcache2mem_req_i(req0), .dcache2mem_wr_i(wr0), .dcache2mem_kill_i(kill0),
        .dcache2mem_addr_i(addr0), .dcache2mem_wdata_i(wdata0),
        .mem2dcache_ack_o(ack0), .mem2dcache_rdata_o(rdata0), .mem_busy_o(busy0)
    );

    int checks = 0;
    int errors = 0;
    logic [C_LW-1:0] exp_q[$];

    localparam logic [C_LW-1:0] C_D1 = 128'h44443333_22221111_00000000_DEADBEEF;

    // Counts negedges until ack; -1 on timeout.
    task automatic wait_ack(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic w, input logic [C_AW-1:0] a, input logic [C_LW-1:0] d,
                          output int n, output logic [C_LW-1:0] rd);
        req = 1'b1; wr = w; addr = a; wdata = d;
        wait_ack(n);
        rd  = rdata;
        req = 1'b0;
    endtask

    task automatic do_txn0(input logic w, input logic [C_AW-1:0] a, input logic [C_LW-1:0] d,
                           input bit toggle, output int n, output logic [C_LW-1:0] rd);
        req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (toggle && k == 2) begin
                req0  = 1'b0;
                addr0 = 32'h0000_0080;
            end
            if (ack0) begin
                n = k;
                break;
            end
        end
        rd   = rdata0;
        req0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int n; logic [C_LW-1:0] rd, e;
        do_txn(1'b1, 32'h40, C_D1, n, rd);
        checks++; if (n !== 7) begin errors++; $display("FAIL wr_latency: got %0d expected 7", n); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL wr_rdata_hold: got %h expected 0", rd); end
        @(negedge clk);
        exp_q.push_back(C_D1);
        do_txn(1'b0, 32'h40, '0, n, rd);
        checks++; if (n !== 7) begin errors++; $display("FAIL rd_latency: got %0d expected 7", n); end
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL rd_data: got %h expected %h", rd, e); end
        @(negedge clk);
        checks++; if (rdata !== e || busy !== 1'b0) begin
            errors++; $display("FAIL rd_hold: got %h busy %b expected %h busy 0", rdata, busy, e);
        end
    endtask

    task automatic test_back_to_back();
        int n; logic [C_LW-1:0] rd, e;
        logic [C_LW-1:0] la = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
        logic [C_LW-1:0] lb = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
        do_txn(1'b1, 32'h200, lb, n, rd);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h100; wdata = la;
        wait_ack(n);
        checks++; if (n !== 7) begin errors++; $display("FAIL b2b_wr_latency: got %0d expected 7", n); end
        wr = 1'b0; addr = 32'h200; wdata = '0;
        exp_q.push_back(lb);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy %b expected 0", busy); end
        wait_ack(n);
        rd  = rdata;
        req = 1'b0;
        checks++; if (n !== 7) begin errors++; $display("FAIL b2b_rd_latency: got %0d expected 7", n); end
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL b2b_rd_data: got %h expected %h", rd, e); end
        @(negedge clk);
        exp_q.push_back(la);
        do_txn(1'b0, 32'h100, '0, n, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL b2b_wb_data: got %h expected %h", rd, e); end
        @(negedge clk);
    endtask

    task automatic test_kill_xfer();
        int n; logic [C_LW-1:0] rd, e; bit seen;
        do_txn(1'b1, 32'h80, '0, n, rd);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h80; wdata = '1;
        repeat (5) @(negedge clk);
        kill = 1'b1; req = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL kill_xfer_ack: got %b expected 0", ack); end
        @(negedge clk);
        kill = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_xfer_busy: got %b expected 0", busy); end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_xfer_noack: got ack expected none"); end
        exp_q.push_back({32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF});
        do_txn(1'b0, 32'h80, '0, n, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL kill_partial: got %h expected %h", rd, e); end
        @(negedge clk);
    endtask

    task automatic test_kill_resp();
        int n; logic [C_LW-1:0] rd, e, prev;
        kill = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h40;
        @(negedge clk);
        kill = 1'b0; req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_idle_accept: busy %b expected 0", busy); end
        prev = rdata;
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        repeat (7) @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL kill_resp_pre_ack: got %b expected 1", ack); end
        kill = 1'b1; req = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL kill_resp_ack: got %b expected 0", ack); end
        @(negedge clk);
        kill = 1'b0;
        checks++; if (busy !== 1'b0 || rdata !== prev) begin
            errors++; $display("FAIL kill_resp_state: busy %b rdata %h expected busy 0 rdata %h", busy, rdata, prev);
        end
        exp_q.push_back(C_D1);
        do_txn(1'b0, 32'h40, '0, n, rd);
        e = exp_q.pop_front();
        checks++; if (n !== 7 || rd !== e) begin
            errors++; $display("FAIL kill_resp_next: lat %0d data %h expected 7 %h", n, rd, e);
        end
        @(negedge clk);
    endtask

    task automatic test_alias();
        int n; logic [C_LW-1:0] rd, e;
        logic [C_LW-1:0] le = 128'h13572468_0F0F0F0F_CAFEF00D_12345678;
        do_txn(1'b1, 32'h10, le, n, rd);
        @(negedge clk);
        exp_q.push_back(le);
        do_txn(1'b0, 32'h10 + C_ML*16, '0, n, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL alias_data: got %h expected %h", rd, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n; logic [C_LW-1:0] rd, e;
        req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = '1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ack !== 1'b0 || rdata !== '0) begin
            errors++; $display("FAIL reset_mid: busy %b ack %b rdata %h expected 0 0 0", busy, ack, rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Beat 0 was written before reset; beat 1 was cut by reset.
        exp_q.push_back({C_D1[127:32], 32'hFFFFFFFF});
        do_txn(1'b0, 32'h40, '0, n, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL reset_retain: got %h expected %h", rd, e); end
        @(negedge clk);
    endtask

    task automatic test_wait0();
        int n; logic [C_LW-1:0] rd, e;
        logic [C_LW-1:0] lf = 128'hF00DF00D_BEEFBEEF_01234567_89ABCDEF;
        do_txn0(1'b1, 32'h40, lf, 1'b0, n, rd);
        checks++; if (n !== 5) begin errors++; $display("FAIL w0_wr_latency: got %0d expected 5", n); end
        @(negedge clk);
        exp_q.push_back(lf);
        do_txn0(1'b0, 32'h40, '0, 1'b1, n, rd);
        checks++; if (n !== 5) begin errors++; $display("FAIL w0_rd_latency: got %0d expected 5", n); end
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL w0_rd_data: got %h expected %h", rd, e); end
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL w0_busy: got %b expected 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_kill_xfer();
        test_kill_resp();
        test_alias();
        test_reset_mid();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
